clkdiv_arbiter: RTL and testbench
=================================

# clkdiv_arbiter

Shares one `divide_by_N` clock divider among NREQ requesters, each of which wants the CPLD's divided clock at its own divisor. The block arbitrates round-robin and latches the winner's divisor. It holds the divider in reset while the divisor changes, enables it for the owner, and drains it with enable low before any handover, so every divisor change is glitch-free. It sits between the requesters and the divider's `reset`/`enable`/`n` inputs.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `SETTLE`, 4: cycles the divider is held disabled before handover (≥1).
- `QUANTUM`, 0: max RUN cycles before preemption when others wait; 0 = no preemption; 16-bit counter.
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  NREQ  level request per requester.
- `req_n`  in  8*NREQ  divisor per requester; requester i uses bits [8i+7:8i].
- `grant`  out  NREQ  one-hot (or zero) grant, registered.
- `div_reset`  out  1  to divider reset, active-high, registered.
- `div_enable`  out  1  to divider enable, registered.
- `div_n`  out  8  latched divisor to divider, registered.
- `owner`  out  clog2(NREQ)  index of current/last owner.
- `busy`  out  1  high in LOAD, RUN, DRAIN.

## Operation
- Reset values, applied at any edge with `reset`=0 including mid-operation: state IDLE, grant=0, div_enable=0, div_reset=1, div_n=0, owner=0, busy=0, rr pointer=0, counters=0.
- IDLE: div_reset=1, div_enable=0.
  - If any `req` bit is set, pick the first set bit at or after the pointer, wrapping.
  - Latch owner and div_n ← req_n[owner], then go to LOAD.
- LOAD (1 cycle): div_reset=1 and busy=1.
  - If req[owner] is still high, go to RUN.
  - Else set pointer ← owner+1 mod NREQ and go to IDLE. No grant is issued.
- RUN: div_reset=0, div_enable=1, grant[owner]=1. The quantum counter increments each RUN cycle.
  - Go to DRAIN when req[owner]=0.
  - Also go to DRAIN when QUANTUM≠0, the counter reaches QUANTUM−1, and any other req bit is set.
- DRAIN (exactly SETTLE cycles): grant=0, div_enable=0, div_reset=0. Because the divider output is forced low while disabled, its output ends low.
  - On the last cycle, set pointer ← owner+1 mod NREQ, div_reset ← 1, and go to IDLE.
- `div_n` is held through RUN and DRAIN. Changes to req_n[owner] during RUN are ignored; a new divisor needs release and re-request.
- Divisors 0 and 1 are forwarded unchanged (the divider bypasses to clk); this is not an error.
- Owner re-requesting during DRAIN is not favoured. Its pointer has advanced past it, so it is served after others in round-robin.

## Timing
- req[i] sampled high at edge E0 in IDLE: div_n and owner are valid after E0, and state is LOAD.
- After E1: grant[i]=1, div_enable=1, div_reset=0.
- Request-to-grant latency is 2 edges.
- req[owner] sampled low at edge Ek: grant=0 and div_enable=0 after Ek, in the same edge.
- After Ek+SETTLE: div_reset=1, state IDLE.
- Minimum gap between consecutive grants is SETTLE+2 cycles (DRAIN, IDLE, LOAD).
- The owner dropping req while another raises req in the same cycle still goes through the full DRAIN; no direct handover.
- Preemption with QUANTUM=Q: grant stays high for exactly Q cycles, then DRAIN.
- `grant` never has more than one bit set.
- `div_enable`=1 only while state is RUN and `div_reset`=0.

## Test plan
- Reset, then idle: reset=0 for 2 cycles -> div_reset=1, div_enable=0, grant=0, div_n=0, busy=0.
- Single request: req=0001, req_n[0]=8'd6 at E0 -> div_n=6 after E0, grant=0001 and div_enable=1 after E1. Drop req -> enable low next edge, div_reset=1 after SETTLE=4 edges.
- Round-robin: req=1111 continuously with each holder releasing after 10 cycles -> grants in order 0,1,2,3,0. Each gap is 6 cycles, and grant is never multi-hot.
- Preemption: QUANTUM=16, req[0] held, req[2] raised -> grant[0] high exactly 16 cycles, then grant[2] after 6 idle cycles. Changing req_n[0] mid-RUN leaves div_n unchanged.
- Abort in LOAD and mid-run reset:
  - req[1] pulsed for 1 cycle -> no grant, returns to IDLE, pointer=2.
  - reset=0 asserted during RUN -> all outputs return to reset values after that edge.

Source files
------------

// File: rtl/clkdiv_arbiter.sv
// ---------------------------------------------------------------------------
// clkdiv_arbiter
//
// Shares one divide_by_N clock divider among NREQ requesters. Requests are
// arbitrated round-robin; the winner's divisor is latched and presented to
// the divider while the divider is held in reset, then the divider is
// enabled for the owner. Before any handover the divider is drained with
// enable low for SETTLE cycles so every divisor change is glitch-free.
//
// Handshake: req[i] is a level request held by requester i for as long as it
// wants the divided clock. grant[i] (registered) is high exactly while the
// divider runs for requester i. Dropping req[i] is the release; it is seen
// at the next rising edge, after which grant and div_enable fall together.
// A request that disappears before its grant is issued is abandoned.
//
// Ports
//   clk         system clock, everything on the rising edge
//   reset       synchronous, active-low reset
//   req         level request per requester
//   req_n       divisor per requester, requester i on bits [8i+7:8i]
//   grant       one-hot (or zero) grant, registered
//   div_reset   divider reset, active high, registered
//   div_enable  divider enable, registered
//   div_n       latched divisor for the divider, registered
//   owner       index of the current / last owner
//   busy        high in LOAD, RUN and DRAIN
//   state_dbg   FSM state: 0 IDLE, 1 LOAD, 2 RUN, 3 DRAIN
// ---------------------------------------------------------------------------
module clkdiv_arbiter #(
   parameter int NREQ    = 4,
   parameter int SETTLE  = 4,
   parameter int QUANTUM = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NREQ-1:0]           req,
   input  logic [8*NREQ-1:0]         req_n,
   output logic [NREQ-1:0]           grant,
   output logic                      div_reset,
   output logic                      div_enable,
   output logic [7:0]                div_n,
   output logic [$clog2(NREQ)-1:0]   owner,
   output logic                      busy,
   output logic [1:0]                state_dbg
);

   localparam int OW = $clog2(NREQ);
   localparam logic [15:0] QLAST = (QUANTUM > 0) ? 16'(QUANTUM - 1) : 16'd0;
   localparam logic [15:0] SLAST = 16'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   ptr_q, ptr_d;
   logic [OW-1:0]   owner_d;
   logic [15:0]     qcnt_q, qcnt_d;
   logic [15:0]     scnt_q, scnt_d;
   logic [NREQ-1:0] grant_d;
   logic            div_reset_d;
   logic            div_enable_d;
   logic [7:0]      div_n_d;
   logic            busy_d;

   logic [7:0]      req_n_arr [NREQ];
   logic [OW-1:0]   pick;
   logic            found;
   logic [OW:0]     idx;
   logic [NREQ-1:0] own_mask;
   logic [OW-1:0]   owner_inc;
   logic            others;
   logic            preempt;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_n_arr[g] = req_n[8*g +: 8];
   end

   // Round-robin search: first set request at or after the pointer,
   // wrapping. idx is one bit wider so ptr+k never overflows before the
   // modulo correction.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = {1'b0, ptr_q} + (OW+1)'(k);
         if (idx >= (OW+1)'(NREQ)) idx = idx - (OW+1)'(NREQ);
         if (!found && req[idx[OW-1:0]]) begin
            found = 1'b1;
            pick  = idx[OW-1:0];
         end
      end
   end

   always_comb begin
      own_mask        = '0;
      own_mask[owner] = 1'b1;
   end

   assign owner_inc = (owner == OW'(NREQ - 1)) ? '0 : owner + OW'(1);
   assign others    = |(req & ~own_mask);
   // Preemption only matters when somebody else is actually waiting.
   assign preempt   = (QUANTUM != 0) && (qcnt_q == QLAST) && others;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      owner_d      = owner;
      qcnt_d       = qcnt_q;
      scnt_d       = scnt_q;
      grant_d      = grant;
      div_reset_d  = div_reset;
      div_enable_d = div_enable;
      div_n_d      = div_n;
      case (state_q)
         IDLE: begin
            div_reset_d  = 1'b1;
            div_enable_d = 1'b0;
            grant_d      = '0;
            if (found) begin
               owner_d = pick;
               div_n_d = req_n_arr[pick];
               state_d = LOAD;
            end
         end
         LOAD: begin
            // The divider is still in reset here with the new divisor
            // applied, so releasing it next cycle starts cleanly.
            if (req[owner]) begin
               state_d      = RUN;
               grant_d      = own_mask;
               div_enable_d = 1'b1;
               div_reset_d  = 1'b0;
               qcnt_d       = '0;
            end else begin
               ptr_d   = owner_inc;
               state_d = IDLE;
            end
         end
         RUN: begin
            if (!req[owner] || preempt) begin
               state_d      = DRAIN;
               grant_d      = '0;
               div_enable_d = 1'b0;
               div_reset_d  = 1'b0;
               scnt_d       = '0;
            end else begin
               qcnt_d = qcnt_q + 16'd1;
            end
         end
         DRAIN: begin
            // Enable is low, so the divider output settles low before it is
            // put back into reset for the next owner.
            if (scnt_q == SLAST) begin
               state_d     = IDLE;
               div_reset_d = 1'b1;
               ptr_d       = owner_inc;
            end else begin
               scnt_d = scnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         owner      <= '0;
         qcnt_q     <= '0;
         scnt_q     <= '0;
         grant      <= '0;
         div_reset  <= 1'b1;
         div_enable <= 1'b0;
         div_n      <= '0;
         busy       <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner      <= owner_d;
         qcnt_q     <= qcnt_d;
         scnt_q     <= scnt_d;
         grant      <= grant_d;
         div_reset  <= div_reset_d;
         div_enable <= div_enable_d;
         div_n      <= div_n_d;
         busy       <= busy_d;
      end
   end

   assign state_dbg = state_q;

endmodule

// File: tb/tb_clkdiv_arbiter.sv
// ---------------------------------------------------------------------------
// tb_clkdiv_arbiter
//
// Bench for clkdiv_arbiter with NREQ=4, SETTLE=4, QUANTUM=16. Stimulus is
// issued in batches of simultaneous requests; a grant-level model predicts
// the sequence of (owner, divisor, grant length, back-to-back gap) and a
// monitor process compares each completed grant against it. Timing points
// (reset, LOAD, RUN, DRAIN, abort, mid-run reset) are queued as
// full-output snapshots stamped with the cycle they must appear in.
// ---------------------------------------------------------------------------
module tb_clkdiv_arbiter;

   localparam int NREQ    = 4;
   localparam int SETTLE  = 4;
   localparam int QUANTUM = 16;
   localparam int W       = 28;
   localparam int BUDGET  = 1000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req = '0;
   logic [31:0] req_n = '0;
   logic [3:0]  grant;
   logic        div_reset;
   logic        div_enable;
   logic [7:0]  div_n;
   logic [1:0]  owner;
   logic        busy;
   logic [1:0]  state_dbg;

   always #5 clk = ~clk;

   clkdiv_arbiter #(
      .NREQ(NREQ), .SETTLE(SETTLE), .QUANTUM(QUANTUM)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_n(req_n),
      .grant(grant), .div_reset(div_reset), .div_enable(div_enable),
      .div_n(div_n), .owner(owner), .busy(busy), .state_dbg(state_dbg)
   );

   // ---------------- cycle counter ----------------
   logic [31:0] cyc = '0;
   always @(posedge clk) cyc <= cyc + 32'd1;

   // ---------------- scoreboard state ----------------
   // exp_q entry: {back_to_back, owner[2:0], div_n[7:0], length[15:0]}
   logic [W-1:0] exp_q[$];

   typedef struct packed {
      logic [31:0] stamp;
      logic [18:0] expv;
      logic        ff;
      logic [95:0] name;
   } dchk_t;
   dchk_t dir_q[$];

   int   checks = 0;
   int   errors = 0;
   logic track_en = 1'b1;
   logic end_req = 1'b0;
   logic mon_done = 1'b0;

   int          hold [4];
   logic [7:0]  nval [4];
   int          model_ptr = 0;

   function automatic logic [18:0] snap(input logic [1:0] st, input logic bz,
                                        input logic rs, input logic en,
                                        input logic [1:0] ow, input logic [3:0] gr,
                                        input logic [7:0] n);
      return {st, bz, rs, en, ow, gr, n};
   endfunction

   function automatic logic [W-1:0] pk(input logic b2b, input int o, input int n,
                                       input int len);
      return {b2b, 3'(o), 8'(n), 16'(len)};
   endfunction

   task automatic expect_at(input int k, input logic [95:0] name, input logic [18:0] v);
      dchk_t d;
      d.stamp = cyc + 32'(k);
      d.expv  = v;
      d.ff    = 1'b0;
      d.name  = name;
      dir_q.push_back(d);
   endtask

   task automatic flag_fail(input logic [95:0] name);
      dchk_t d;
      d.stamp = cyc + 32'd1;
      d.expv  = '0;
      d.ff    = 1'b1;
      d.name  = name;
      dir_q.push_back(d);
   endtask

   // ---------------- monitor ----------------
   logic       in_grant = 1'b0;
   int         gap_cnt = 0;
   int         cur_len = 0;
   int         cur_gap = 0;
   logic [1:0] cur_owner = '0;
   logic [7:0] cur_n = '0;

   always @(negedge clk) begin
      logic [18:0]  o;
      dchk_t        d;
      logic [W-1:0] e;
      logic         bad;
      o = {state_dbg, busy, div_reset, div_enable, owner, grant, div_n};

      bad = !$onehot0(grant) || (div_enable != (grant != 4'd0)) ||
            (div_enable && div_reset) || (div_enable && state_dbg != 2'd2) ||
            (grant != 4'd0 && grant != (4'b0001 << owner));
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL invariant actual grant=%b en=%b rst=%b owner=%0d state=%0d required onehot grant at owner, enable only in RUN without reset",
                  grant, div_enable, div_reset, owner, state_dbg);
      end

      while (dir_q.size() != 0 && dir_q[0].stamp <= cyc) begin
         d = dir_q.pop_front();
         checks++;
         if (d.ff || o != d.expv) begin
            errors++;
            $display("FAIL %0s actual=%h required=%h (state,busy,rst,en,owner,grant,div_n)",
                     d.name, o, d.expv);
         end
      end

      if (!track_en) begin
         in_grant = 1'b0;
         gap_cnt  = 0;
      end else if (grant != 4'd0) begin
         if (!in_grant) begin
            in_grant  = 1'b1;
            cur_owner = owner;
            cur_n     = div_n;
            cur_len   = 1;
            cur_gap   = gap_cnt;
         end else begin
            cur_len++;
            checks++;
            if (owner != cur_owner || div_n != cur_n) begin
               errors++;
               $display("FAIL hold_in_run actual owner=%0d div_n=%0d required owner=%0d div_n=%0d",
                        owner, div_n, cur_owner, cur_n);
            end
         end
      end else if (in_grant) begin
         in_grant = 1'b0;
         gap_cnt  = 1;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant actual owner=%0d div_n=%0d len=%0d required no grant",
                     cur_owner, cur_n, cur_len);
         end else begin
            e = exp_q.pop_front();
            if ({1'b0, cur_owner} != e[26:24] || cur_n != e[23:16] ||
                cur_len != int'(e[15:0]) || (e[27] && cur_gap != SETTLE + 2)) begin
               errors++;
               $display("FAIL grant_txn actual owner=%0d div_n=%0d len=%0d gap=%0d required owner=%0d div_n=%0d len=%0d gap=%0d checked=%0d",
                        cur_owner, cur_n, cur_len, cur_gap, e[26:24], e[23:16], e[15:0],
                        SETTLE + 2, e[27]);
            end
         end
      end else begin
         gap_cnt++;
      end

      if (end_req && !mon_done) begin
         checks++;
         if (exp_q.size() != 0 || dir_q.size() != 0) begin
            errors++;
            $display("FAIL leftover actual pending_grants=%0d pending_snapshots=%0d required 0 0",
                     exp_q.size(), dir_q.size());
         end
         mon_done = 1'b1;
      end
   end

   // ---------------- driver tasks ----------------
   // Requesters in act all raise req together while the arbiter is idle;
   // each keeps requesting until it has held the grant for hold[i] cycles
   // in total, scrambling its divisor while granted.
   task automatic run_batch(input logic [3:0] act);
      int   rem [4];
      int   got [4];
      int   p, i, j, len, n;
      logic others, first, done;
      p     = model_ptr;
      first = 1'b1;
      for (int k = 0; k < 4; k++) rem[k] = act[k] ? hold[k] : 0;
      forever begin
         i = -1;
         for (int k = 0; k < 4; k++) begin
            j = (p + k) % NREQ;
            if (i < 0 && rem[j] > 0) i = j;
         end
         if (i < 0) break;
         others = 1'b0;
         for (int k = 0; k < 4; k++) if (k != i && rem[k] > 0) others = 1'b1;
         len = (others && rem[i] > QUANTUM) ? QUANTUM : rem[i];
         exp_q.push_back(pk(!first, i, int'(nval[i]), len));
         rem[i] -= len;
         p = (i + 1) % NREQ;
         first = 1'b0;
      end
      model_ptr = p;

      for (int k = 0; k < 4; k++) begin
         req_n[8*k +: 8] = nval[k];
         got[k] = 0;
      end
      req  = act;
      done = 1'b0;
      n    = 0;
      while (!done && n < BUDGET) begin
         @(negedge clk);
         n++;
         for (int k = 0; k < 4; k++) begin
            if (grant[k] && req[k]) begin
               got[k]++;
               req_n[8*k +: 8] = 8'($urandom_range(0, 255));
               if (got[k] == hold[k]) req[k] = 1'b0;
            end else begin
               req_n[8*k +: 8] = nval[k];
            end
         end
         if (req == 4'd0 && !busy) done = 1'b1;
      end
      if (!done) begin
         flag_fail("timeout");
         req = 4'd0;
         exp_q.delete();
         repeat (SETTLE + 4) @(negedge clk);
      end
   endtask

   // One-cycle request pulse: latched in IDLE, abandoned in LOAD.
   task automatic abort_pulse(input int i);
      logic [7:0] v;
      v = 8'($urandom_range(0, 255));
      req_n[8*i +: 8] = v;
      req[i] = 1'b1;
      expect_at(1, "abort_load", snap(2'd1, 1'b1, 1'b1, 1'b0, 2'(i), 4'd0, v));
      @(negedge clk);
      req[i] = 1'b0;
      expect_at(1, "abort_idle", snap(2'd0, 1'b0, 1'b1, 1'b0, 2'(i), 4'd0, v));
      @(negedge clk);
      model_ptr = (i + 1) % NREQ;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic seen;
      reset = 1'b0;
      @(negedge clk);
      expect_at(1, "reset_idle", snap(2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 8'd0));
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Single request with exact timing.
      req_n[7:0] = 8'd6;
      req = 4'b0001;
      exp_q.push_back(pk(1'b0, 0, 6, 3));
      expect_at(1, "load", snap(2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 4'd0, 8'd6));
      expect_at(2, "run", snap(2'd2, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0001, 8'd6));
      repeat (4) @(negedge clk);
      req = 4'd0;
      expect_at(1, "drain_first", snap(2'd3, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 8'd6));
      expect_at(SETTLE, "drain_last", snap(2'd3, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 8'd6));
      expect_at(SETTLE + 1, "idle_again", snap(2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 8'd6));
      repeat (SETTLE + 2) @(negedge clk);
      model_ptr = 1;

      // Pointer to 0, then full round-robin with boundary divisors.
      abort_pulse(3);
      nval[0] = 8'd0;   nval[1] = 8'd1;   nval[2] = 8'd200; nval[3] = 8'd255;
      for (int k = 0; k < 4; k++) hold[k] = 10;
      run_batch(4'b1111);

      // Preemption: requester 0 holds past the quantum while 2 waits.
      nval[0] = 8'd33; nval[2] = 8'd77;
      hold[0] = 25;    hold[2] = 5;
      run_batch(4'b0101);

      // Abort on 1 leaves the pointer at 2, so 2 beats 1.
      abort_pulse(1);
      nval[1] = 8'd11; nval[2] = 8'd22;
      hold[1] = 3;     hold[2] = 4;
      run_batch(4'b0110);

      // Randomized batches and aborts.
      for (int it = 0; it < 40; it++) begin
         if ($urandom_range(0, 4) == 0) begin
            abort_pulse(int'($urandom_range(0, 3)));
         end else begin
            for (int k = 0; k < 4; k++) begin
               hold[k] = int'($urandom_range(1, 40));
               if ($urandom_range(0, 7) == 0) nval[k] = 8'($urandom_range(0, 1));
               else nval[k] = 8'($urandom_range(0, 255));
            end
            run_batch(4'($urandom_range(1, 15)));
         end
      end

      // Reset asserted mid-RUN.
      track_en = 1'b0;
      req_n[31:24] = 8'd9;
      req = 4'b1000;
      seen = 1'b0;
      for (int k = 0; k < 50 && !seen; k++) begin
         @(negedge clk);
         if (grant[3]) seen = 1'b1;
      end
      if (!seen) flag_fail("timeout");
      repeat (3) @(negedge clk);
      reset = 1'b0;
      expect_at(1, "midrun_reset", snap(2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 8'd0));
      @(negedge clk);
      reset = 1'b1;
      req = 4'd0;
      model_ptr = 0;
      @(negedge clk);
      track_en = 1'b1;
      @(negedge clk);

      // Pointer back at 0 after reset: 1 is served before 3.
      nval[1] = 8'd5; nval[3] = 8'd250;
      hold[1] = 7;    hold[3] = 2;
      run_batch(4'b1010);

      repeat (3) @(negedge clk);
      end_req = 1'b1;
      for (int k = 0; k < 10 && !mon_done; k++) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
